// File: rtl/snn_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snn_sched_pkg
//  Purpose  : Shared types and default constants for the SNN timestep
//             scheduler and its optional spike-counter bank.
//  Contents : state_e        - scheduler state encoding
//             *_DEFAULT      - default values for N, M, SUB_STEPS, STEP_W
//             CNT_W/CNT_MAX  - width and ceiling of per-neuron spike counters
//  Revision : 1.0 - initial release
// ============================================================================
package snn_sched_pkg;

  localparam int N_DEFAULT         = 4;
  localparam int M_DEFAULT         = 8;
  localparam int SUB_STEPS_DEFAULT = 4;
  localparam int STEP_W_DEFAULT    = 8;

  // Per-neuron spike counters saturate instead of wrapping.
  localparam int               CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    INTEG  = 3'd2,
    DRAIN  = 3'd3,
    EMIT   = 3'd4,
    FINISH = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/snn_spike_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : snn_spike_counter_bank
//  Purpose  : N independent saturating spike counters, one per neuron.
//  Ports    : clk      - system clock
//             reset    - synchronous, active-low reset (clears all counters)
//             clear    - synchronous clear of all counters
//             inc_en   - qualifies an increment this cycle
//             inc_mask - per-neuron increment request (bit i -> counter i)
//             counts   - packed counter values, counter i at [i*CNT_W +: CNT_W]
//  Revision : 1.0 - initial release
// ============================================================================
module snn_spike_counter_bank
  import snn_sched_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc_en,
  input  logic [N-1:0]       inc_mask,
  output logic [N*CNT_W-1:0] counts
);

  generate
    for (genvar g = 0; g < N; g++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Clear wins; an increment at the ceiling is dropped (saturation).
      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (inc_en && inc_mask[g] && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign counts[g*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/snn_timestep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : snn_timestep_scheduler
//  Purpose  : Sequences one SNN neuron layer through discrete timesteps.
//             Each timestep takes one input spike vector, enables the layer
//             for SUB_STEPS cycles (one delay-clock pulse on the first),
//             ORs the layer output spikes over those cycles plus one drain
//             cycle, and emits the result vector.
//  Ports    : clk, reset (sync, active-low)
//             start/stop/num_steps          - run control
//             in_valid/in_ready/in_spikes   - input spike vector handshake
//             layer_enable/layer_delay_clk/layer_input_spikes - to the layer
//             layer_output_spikes           - from the layer
//             out_valid/out_ready/out_spikes/out_step - result handshake
//             busy, done                    - status
//             spike_counts                  - per-neuron saturating counts
//                                             (only with the macro below)
//  Options  : SNN_SCHED_SPIKE_COUNT_EN adds spike_counts and the counter bank.
//  Revision : 1.0 - initial release
// ============================================================================
module snn_timestep_scheduler
  import snn_sched_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int M         = M_DEFAULT,
  parameter int SUB_STEPS = SUB_STEPS_DEFAULT,
  parameter int STEP_W    = STEP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M-1:0]      in_spikes,
  output logic              layer_enable,
  output logic              layer_delay_clk,
  output logic [M-1:0]      layer_input_spikes,
  input  logic [N-1:0]      layer_output_spikes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_spikes,
  output logic [STEP_W-1:0] out_step,
  output logic              busy,
  output logic              done
`ifdef SNN_SCHED_SPIKE_COUNT_EN
  ,
  output logic [N*CNT_W-1:0] spike_counts
`endif
);

  localparam int                SUB_W    = (SUB_STEPS > 1) ? $clog2(SUB_STEPS) : 1;
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SUB_STEPS - 1);
  localparam logic [SUB_W-1:0]  SUB_ONE  = SUB_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0]   num_steps_q, num_steps_d;
  logic [SUB_W-1:0]    sub_cnt_q, sub_cnt_d;
  logic [N-1:0]        spike_acc_q, spike_acc_d;
  logic [M-1:0]        in_vec_q, in_vec_d;
  logic                stop_req_q, stop_req_d;

  // Registered outputs, decoded from the next state.
  logic                in_ready_q, in_ready_d;
  logic                layer_enable_q, layer_enable_d;
  logic                layer_delay_clk_q, layer_delay_clk_d;
  logic [M-1:0]        layer_input_spikes_q, layer_input_spikes_d;
  logic                out_valid_q, out_valid_d;
  logic [N-1:0]        out_spikes_q, out_spikes_d;
  logic [STEP_W-1:0]   out_step_q, out_step_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                in_fire;
  logic                out_fire;
  logic                last_step;

  assign in_fire   = (state_q == FETCH) && in_valid && in_ready_q;
  assign out_fire  = (state_q == EMIT) && out_valid_q && out_ready;
  // num_steps == 0 means free-run: no step is ever the last one.
  assign last_step = (num_steps_q != '0) && (step_cnt_q == (num_steps_q - STEP_ONE));

  // --------------------------------------------------------------------------
  // State register and datapath flops
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q              <= IDLE;
      step_cnt_q           <= '0;
      num_steps_q          <= '0;
      sub_cnt_q            <= '0;
      spike_acc_q          <= '0;
      in_vec_q             <= '0;
      stop_req_q           <= 1'b0;
      in_ready_q           <= 1'b0;
      layer_enable_q       <= 1'b0;
      layer_delay_clk_q    <= 1'b0;
      layer_input_spikes_q <= '0;
      out_valid_q          <= 1'b0;
      out_spikes_q         <= '0;
      out_step_q           <= '0;
      busy_q               <= 1'b0;
      done_q               <= 1'b0;
    end else begin
      state_q              <= state_d;
      step_cnt_q           <= step_cnt_d;
      num_steps_q          <= num_steps_d;
      sub_cnt_q            <= sub_cnt_d;
      spike_acc_q          <= spike_acc_d;
      in_vec_q             <= in_vec_d;
      stop_req_q           <= stop_req_d;
      in_ready_q           <= in_ready_d;
      layer_enable_q       <= layer_enable_d;
      layer_delay_clk_q    <= layer_delay_clk_d;
      layer_input_spikes_q <= layer_input_spikes_d;
      out_valid_q          <= out_valid_d;
      out_spikes_q         <= out_spikes_d;
      out_step_q           <= out_step_d;
      busy_q               <= busy_d;
      done_q               <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        // An arriving vector takes priority over a pending stop.
        if (in_fire)                  state_d = INTEG;
        else if (stop_req_q || stop)  state_d = FINISH;
      end
      INTEG: begin
        if (sub_cnt_q == SUB_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = EMIT;
      end
      EMIT: begin
        if (out_fire) begin
          if (stop_req_q || last_step) state_d = FINISH;
          else                         state_d = FETCH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: counters, accumulator, latched input vector, stop request
  // --------------------------------------------------------------------------
  always_comb begin
    step_cnt_d  = step_cnt_q;
    num_steps_d = num_steps_q;
    sub_cnt_d   = sub_cnt_q;
    spike_acc_d = spike_acc_q;
    in_vec_d    = in_vec_q;
    // stop is only remembered inside a run; IDLE always leaves it clear.
    stop_req_d  = (state_q == IDLE) ? 1'b0 : (stop_req_q | stop);

    case (state_q)
      IDLE: begin
        if (start) begin
          step_cnt_d  = '0;
          num_steps_d = num_steps;
        end
      end
      FETCH: begin
        if (in_fire) begin
          in_vec_d    = in_spikes;
          spike_acc_d = '0;
          sub_cnt_d   = '0;
        end
      end
      INTEG: begin
        spike_acc_d = spike_acc_q | layer_output_spikes;
        if (sub_cnt_q != SUB_LAST) sub_cnt_d = sub_cnt_q + SUB_ONE;
      end
      DRAIN: begin
        // The layer output is registered, so the last enabled cycle's
        // spikes only show up here.
        spike_acc_d = spike_acc_q | layer_output_spikes;
      end
      EMIT: begin
        // Free-run relies on the natural wrap of step_cnt.
        if (out_fire && !(stop_req_q || last_step)) step_cnt_d = step_cnt_q + STEP_ONE;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (registered one cycle later so every output is a flop)
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready_d           = (state_d == FETCH);
    busy_d               = (state_d != IDLE);
    layer_enable_d       = (state_d == INTEG);
    layer_delay_clk_d    = (state_d == INTEG) && (state_q != INTEG);
    layer_input_spikes_d = (state_d == INTEG) ? in_vec_d : '0;
    out_valid_d          = (state_d == EMIT);
    out_spikes_d         = (state_d == EMIT) ? spike_acc_d : '0;
    out_step_d           = (state_d == EMIT) ? step_cnt_d : '0;
    done_d               = (state_d == FINISH);
  end

  assign in_ready           = in_ready_q;
  assign layer_enable       = layer_enable_q;
  assign layer_delay_clk    = layer_delay_clk_q;
  assign layer_input_spikes = layer_input_spikes_q;
  assign out_valid          = out_valid_q;
  assign out_spikes         = out_spikes_q;
  assign out_step           = out_step_q;
  assign busy               = busy_q;
  assign done               = done_q;

`ifdef SNN_SCHED_SPIKE_COUNT_EN
  logic cnt_clear;

  assign cnt_clear = (state_q == IDLE) && start;

  snn_spike_counter_bank #(
    .N (N)
  ) u_counter_bank (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .inc_en   (out_fire),
    .inc_mask (out_spikes_q),
    .counts   (spike_counts)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_snn_timestep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snn_timestep_scheduler
//  Purpose  : Self-checking bench for snn_timestep_scheduler (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snn_timestep_scheduler;

  localparam int N      = 4;
  localparam int M      = 8;
  localparam int S      = 4;
  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              stop;
  logic [STEP_W-1:0] num_steps;
  logic              in_valid;
  logic              in_ready;
  logic [M-1:0]      in_spikes;
  logic              layer_enable;
  logic              layer_delay_clk;
  logic [M-1:0]      layer_input_spikes;
  logic [N-1:0]      layer_output_spikes;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_spikes;
  logic [STEP_W-1:0] out_step;
  logic              busy;
  logic              done;
`ifdef SNN_SCHED_SPIKE_COUNT_EN
  logic [N*8-1:0]    spike_counts;
`endif

  always #5 clk = ~clk;

  snn_timestep_scheduler #(
    .N         (N),
    .M         (M),
    .SUB_STEPS (S),
    .STEP_W    (STEP_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .stop                (stop),
    .num_steps           (num_steps),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_spikes           (in_spikes),
    .layer_enable        (layer_enable),
    .layer_delay_clk     (layer_delay_clk),
    .layer_input_spikes  (layer_input_spikes),
    .layer_output_spikes (layer_output_spikes),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_spikes          (out_spikes),
    .out_step            (out_step),
    .busy                (busy),
    .done                (done)
`ifdef SNN_SCHED_SPIKE_COUNT_EN
    ,
    .spike_counts        (spike_counts)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed outputs packed {busy,in_ready,en,dclk,out_valid,done,out_spikes,out_step,layer_in}
  function automatic logic [63:0] pack_obs();
    return 64'({busy, in_ready, layer_enable, layer_delay_clk, out_valid, done,
                out_spikes, out_step, layer_input_spikes});
  endfunction

  // --------------------------------------------------------------------------
  // Behavioural model: a timestep is a timeline counted from the input
  // handshake. Cycles 1..S enable the layer, cycle S+1 is the drain cycle,
  // then the result is offered until accepted.
  // --------------------------------------------------------------------------
  bit          m_active, m_wait_in, m_wait_out, m_finish, m_stop_req;
  int          m_k;
  logic [7:0]  m_step, m_nsteps, m_vec;
  logic [3:0]  m_acc;
  int          m_emits;
  int          m_cnt [N];

  task automatic model_reset();
    m_active = 0; m_wait_in = 0; m_wait_out = 0; m_finish = 0; m_stop_req = 0;
    m_k = 0; m_step = '0; m_nsteps = '0; m_vec = '0; m_acc = '0; m_emits = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [63:0] model_exp();
    logic en;
    en = (m_k >= 1) && (m_k <= S);
    return 64'({m_active, m_active && m_wait_in, en, (m_k == 1), m_wait_out, m_finish,
                (m_wait_out ? m_acc : 4'h0), (m_wait_out ? m_step : 8'h00),
                (en ? m_vec : 8'h00)});
  endfunction

  function automatic logic [N*8-1:0] model_counts();
    logic [N*8-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = m_cnt[i][7:0];
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs about to be applied.
  task automatic model_advance();
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_wait_in = 1; m_step = '0; m_nsteps = num_steps;
        m_stop_req = 0; m_emits = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
    end else if (m_finish) begin
      m_active = 0; m_finish = 0; m_stop_req = 0;
    end else begin
      if (m_wait_in) begin
        if (in_valid) begin
          m_wait_in = 0; m_vec = in_spikes; m_acc = '0; m_k = 1;
        end else if (m_stop_req || stop) begin
          m_wait_in = 0; m_finish = 1;
        end
      end else if (m_k >= 1) begin
        m_acc = m_acc | layer_output_spikes;
        if (m_k == S + 1) begin
          m_k = 0; m_wait_out = 1;
        end else begin
          m_k = m_k + 1;
        end
      end else if (m_wait_out && out_ready) begin
        m_wait_out = 0;
        m_emits++;
        for (int i = 0; i < N; i++)
          if (m_acc[i] && m_cnt[i] < 255) m_cnt[i]++;
        if (m_stop_req || (m_nsteps != 0 && int'(m_step) == int'(m_nsteps) - 1)) m_finish = 1;
        else begin
          m_step = m_step + 8'd1;
          m_wait_in = 1;
        end
      end
      m_stop_req = m_stop_req | stop;
    end
  endtask

  // One run against the model. fast=1: always-ready traffic, neuron 0 spiking,
  // stop asserted once target_emits results have been accepted.
  task automatic run_model(input int nsteps, input bit fast, input int target_emits,
                           input int max_cycles, input string tag);
    for (int c = 0; c < max_cycles; c++) begin
      start     = (c == 0);
      num_steps = 8'(nsteps);
      if (fast) begin
        in_valid            = 1'b1;
        out_ready           = 1'b1;
        in_spikes           = 8'h3C;
        layer_output_spikes = 4'b0001;
        stop                = (m_emits >= target_emits);
      end else begin
        in_valid            = ($urandom_range(0, 9) < 7);
        out_ready           = ($urandom_range(0, 9) < 7);
        in_spikes           = 8'($urandom);
        layer_output_spikes = 4'($urandom);
        stop                = ($urandom_range(0, 39) == 0) || (c > max_cycles / 2);
      end
      model_advance();
      tick();
      check({tag, "_cycle"}, pack_obs(), model_exp());
`ifdef SNN_SCHED_SPIKE_COUNT_EN
      check({tag, "_counts"}, 64'(spike_counts), 64'(model_counts()));
`endif
      if (!m_active) break;
    end
    start = 0; stop = 0; in_valid = 0; out_ready = 0; layer_output_spikes = '0;
    check({tag, "_ended_busy"}, 64'(busy), 64'(0));
  endtask

  // --------------------------------------------------------------------------
  // Directed single-step table: inputs applied, one edge, outputs compared.
  // --------------------------------------------------------------------------
  typedef struct {
    logic       start, in_valid, out_ready;
    logic [3:0] lout;
    logic       e_busy, e_inr, e_en, e_dclk, e_ov, e_done;
    logic [3:0] e_spk;
    logic [7:0] e_step;
    logic [7:0] e_lin;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int en_cnt, dclk_cnt, emit_cnt, done_cnt;
    logic [7:0] steps_seen [3];

    reset = 1'b0; start = 1'b1; stop = 1'b0; num_steps = '0; in_valid = 1'b0;
    in_spikes = '0; layer_output_spikes = '0; out_ready = 1'b0;

    // Reset held with start asserted: nothing may leave IDLE.
    tick(); check("reset_c1", pack_obs(), 64'(0));
    tick(); check("reset_c2", pack_obs(), 64'(0));
    reset = 1'b1; start = 1'b0;
    tick(); check("reset_release_idle", pack_obs(), 64'(0));

    // One-step run: accumulation windows and 5 cycles of backpressure.
    tbl[0]  = '{1'b1,1'b0,1'b0,4'h0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00,8'h00};
    tbl[1]  = '{1'b0,1'b1,1'b0,4'h4, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,8'hA5};
    tbl[2]  = '{1'b0,1'b0,1'b0,4'h0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,8'h00,8'hA5};
    tbl[3]  = '{1'b0,1'b0,1'b0,4'h1, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,8'h00,8'hA5};
    tbl[4]  = '{1'b0,1'b0,1'b0,4'h0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,8'h00,8'hA5};
    tbl[5]  = '{1'b0,1'b0,1'b0,4'h0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00,8'h00};
    tbl[6]  = '{1'b0,1'b1,1'b0,4'h8, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,4'h9,8'h00,8'h00};
    for (int i = 7; i <= 11; i++)
      tbl[i] = '{1'b0,1'b1,1'b0,4'h6, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,4'h9,8'h00,8'h00};
    tbl[12] = '{1'b0,1'b1,1'b1,4'h0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,4'h0,8'h00,8'h00};
    tbl[13] = '{1'b0,1'b0,1'b0,4'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00,8'h00};

    num_steps = 8'd1; in_spikes = 8'hA5;
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start; in_valid = tbl[i].in_valid; out_ready = tbl[i].out_ready;
      layer_output_spikes = tbl[i].lout;
      tick();
      check($sformatf("tbl_row%0d", i), pack_obs(),
            64'({tbl[i].e_busy, tbl[i].e_inr, tbl[i].e_en, tbl[i].e_dclk, tbl[i].e_ov,
                 tbl[i].e_done, tbl[i].e_spk, tbl[i].e_step, tbl[i].e_lin}));
    end
    start = 0; in_valid = 0; out_ready = 0; layer_output_spikes = '0;

    // Three-step run with always-valid input and always-ready output.
    en_cnt = 0; dclk_cnt = 0; emit_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 3; i++) steps_seen[i] = 8'hFF;
    num_steps = 8'd3; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_spikes = 8'h5A;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && busy; c++) begin
      if (layer_enable)    en_cnt++;
      if (layer_delay_clk) dclk_cnt++;
      if (done)            done_cnt++;
      if (out_valid) begin
        if (emit_cnt < 3) steps_seen[emit_cnt] = out_step;
        emit_cnt++;
      end
      tick();
    end
    in_valid = 0; out_ready = 0;
    check("run3_idle_at_end", 64'(busy), 64'(0));
    check("run3_emits", 64'(emit_cnt), 64'(3));
    check("run3_step0", 64'(steps_seen[0]), 64'(0));
    check("run3_step1", 64'(steps_seen[1]), 64'(1));
    check("run3_step2", 64'(steps_seen[2]), 64'(2));
    check("run3_enable_cycles", 64'(en_cnt), 64'(12));
    check("run3_delay_pulses", 64'(dclk_cnt), 64'(3));
    check("run3_done_pulses", 64'(done_cnt), 64'(1));

    // Free-run; stop pulsed while waiting for input ends without another emit.
    num_steps = 8'd0; start = 1'b1;
    tick(); check("stopf_fetch_ready", 64'(in_ready), 64'(1));
    start = 1'b0; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    for (int w = 0; w < 20 && !out_valid; w++) tick();
    check("stopf_first_emit", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    check("stopf_back_in_fetch", 64'({in_ready, out_valid, done}), 64'(3'b100));
    stop = 1'b1;
    tick(); stop = 1'b0;
    check("stopf_finish", 64'({busy, out_valid, done}), 64'(3'b101));
    tick();
    check("stopf_idle", pack_obs(), 64'(0));

    // Reset in the middle of a run: abandoned, no done pulse.
    num_steps = 8'd2; start = 1'b1;
    tick(); start = 1'b0; in_valid = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0; in_valid = 1'b0;
    tick(); check("midreset_cleared", pack_obs(), 64'(0));
    reset = 1'b1;
    tick(); check("midreset_idle1", pack_obs(), 64'(0));
    tick(); check("midreset_idle2", pack_obs(), 64'(0));

    // Randomised runs against the model.
    model_reset();
    for (int r = 0; r < 8; r++)
      run_model((r % 3 == 0) ? 0 : int'($urandom_range(1, 4)), 1'b0, 0, 600,
                $sformatf("rand%0d", r));

    // Long free-run: step counter wraps past 255, counters saturate.
    run_model(0, 1'b1, 300, 3000, "wrap");
`ifdef SNN_SCHED_SPIKE_COUNT_EN
    check("sat_neuron0", 64'(spike_counts[7:0]), 64'(255));
    check("sat_neuron1", 64'(spike_counts[15:8]), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
